ddr_axi_ready_gate: RTL and testbench

DDR_AXI_READY_GATE -- requirements
Module: ddr_axi_ready_gate

---
 rtl/ddr_axi_ready_gate_pkg.sv | 20 ++
 rtl/ddr_out_counter.sv | 25 ++
 rtl/ddr_axi_ready_gate.sv | 133 +++++++++++++
 tb/tb_ddr_axi_ready_gate.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_ready_gate_pkg.sv
// Shared definitions for the DDR AXI ready gate: FSM encoding, counter widths
// and the watchdog terminal-count helper.
package ddr_axi_ready_gate_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_READY     = 2'd2,
        ST_FAULT     = 2'd3
    } gate_state_t;

    localparam int unsigned WD_W     = 24;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SETTLE_W = 8;

    function automatic logic [WD_W-1:0] wd_terminal(input int unsigned ms, input int unsigned mhz);
        return WD_W'(ms * mhz * 1000);
    endfunction

endpackage

// File: rtl/ddr_out_counter.sv
// Outstanding-transaction counter: +1 on issue, -1 on completion, holds on both,
// never wraps below zero or above all-ones.
module ddr_out_counter
    import ddr_axi_ready_gate_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != '1) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ddr_axi_ready_gate.sv
// Holds AXI AW/AR traffic off the DDR controller until init completes and a
// settle guard expires; limits outstanding transactions per direction.
module ddr_axi_ready_gate
    import ddr_axi_ready_gate_pkg::*;
#(
    parameter int unsigned FREQ       = 100,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned MAX_OUT    = 8,
    parameter int unsigned TIMEOUT_MS = 10
) (
    input  logic             clk,
    input  logic             ddr_rstn_i,
    input  logic             ddr_init_done,
    input  logic             s_awvalid,
    output logic             s_awready,
    input  logic             s_arvalid,
    output logic             s_arready,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic             bvalid,
    input  logic             bready,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    output logic             ddr_ready,
    output logic             ddr_timeout,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic [CNT_W-1:0] rd_outstanding
);

    localparam logic [WD_W-1:0]     WD_TERM     = wd_terminal(TIMEOUT_MS, FREQ);
    localparam logic [WD_W-1:0]     WD_LAST     = WD_TERM - 1'b1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]    MAX_CNT     = CNT_W'(MAX_OUT);

    gate_state_t         state;
    logic [WD_W-1:0]     wd_cnt;
    logic [SETTLE_W-1:0] settle_cnt;

    logic allow_aw;
    logic allow_ar;
    logic aw_fire;
    logic ar_fire;
    logic b_fire;
    logic r_done;

    // ddr_ready is a flop mirroring state==READY, so the gate has no decode glitch.
    always_ff @(posedge clk or negedge ddr_rstn_i) begin
        if (!ddr_rstn_i) begin
            state       <= ST_WAIT_INIT;
            wd_cnt      <= '0;
            settle_cnt  <= '0;
            ddr_ready   <= 1'b0;
            ddr_timeout <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_INIT: begin
                    if (ddr_init_done) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        wd_cnt     <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= ST_FAULT;
                        ddr_timeout <= 1'b1;
                        wd_cnt      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!ddr_init_done) begin
                        state      <= ST_WAIT_INIT;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_READY;
                        ddr_ready  <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (!ddr_init_done) begin
                        state     <= ST_WAIT_INIT;
                        ddr_ready <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (ddr_init_done) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ST_WAIT_INIT;
                    ddr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign allow_aw  = ddr_ready && (wr_outstanding < MAX_CNT);
    assign allow_ar  = ddr_ready && (rd_outstanding < MAX_CNT);

    assign m_awvalid = s_awvalid & allow_aw;
    assign s_awready = m_awready & allow_aw;
    assign m_arvalid = s_arvalid & allow_ar;
    assign s_arready = m_arready & allow_ar;

    assign aw_fire   = m_awvalid & m_awready;
    assign ar_fire   = m_arvalid & m_arready;
    assign b_fire    = bvalid & bready;
    assign r_done    = rvalid & rready & rlast;

    ddr_out_counter u_wr_cnt (
        .clk   (clk),
        .rstn  (ddr_rstn_i),
        .inc   (aw_fire),
        .dec   (b_fire),
        .count (wr_outstanding)
    );

    ddr_out_counter u_rd_cnt (
        .clk   (clk),
        .rstn  (ddr_rstn_i),
        .inc   (ar_fire),
        .dec   (r_done),
        .count (rd_outstanding)
    );

endmodule

// File: tb/tb_ddr_axi_ready_gate.sv
// Self-checking bench for ddr_axi_ready_gate: directed timing scenarios plus a
// randomized traffic run against a transaction-level outstanding-count model.
module tb_ddr_axi_ready_gate;

    logic       clk = 1'b0;
    logic       ddr_rstn_i;
    logic       ddr_init_done;
    logic       s_awvalid, s_awready, s_arvalid, s_arready;
    logic       m_awvalid, m_awready, m_arvalid, m_arready;
    logic       bvalid, bready, rvalid, rready, rlast;
    logic       ddr_ready, ddr_timeout;
    logic [3:0] wr_outstanding, rd_outstanding;

    int n_tests = 0;
    int n_fail  = 0;
    int m_wr;
    int m_rd;

    always #5 clk = ~clk;

    ddr_axi_ready_gate #(
        .FREQ       (1),
        .SETTLE_CYC (16),
        .MAX_OUT    (8),
        .TIMEOUT_MS (1)
    ) dut (
        .clk            (clk),
        .ddr_rstn_i     (ddr_rstn_i),
        .ddr_init_done  (ddr_init_done),
        .s_awvalid      (s_awvalid),
        .s_awready      (s_awready),
        .s_arvalid      (s_arvalid),
        .s_arready      (s_arready),
        .m_awvalid      (m_awvalid),
        .m_awready      (m_awready),
        .m_arvalid      (m_arvalid),
        .m_arready      (m_arready),
        .bvalid         (bvalid),
        .bready         (bready),
        .rvalid         (rvalid),
        .rready         (rready),
        .rlast          (rlast),
        .ddr_ready      (ddr_ready),
        .ddr_timeout    (ddr_timeout),
        .wr_outstanding (wr_outstanding),
        .rd_outstanding (rd_outstanding)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ddr_init_done = 1'b0;
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        m_awready = 1'b0; m_arready = 1'b0;
        bvalid = 1'b0; bready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic do_reset();
        ddr_rstn_i = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        ddr_rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        ddr_rstn_i = 1'b0;
        clear_inputs();
        s_awvalid = 1'b1; m_awready = 1'b1; s_arvalid = 1'b1; m_arready = 1'b1;
        #12;
        n_tests++; if (ddr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ddr_ready); end
        n_tests++; if (ddr_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", ddr_timeout); end
        n_tests++; if (wr_outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_wr: got %0d want 0", wr_outstanding); end
        n_tests++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_outstanding); end
        n_tests++; if ({m_awvalid, s_awready, m_arvalid, s_arready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 0000", {m_awvalid, s_awready, m_arvalid, s_arready});
        end
        clear_inputs();
        @(negedge clk);
        ddr_rstn_i = 1'b1;
    endtask

    // Watchdog terminal is 1*1*1000 = 1000 cycles after reset release.
    task automatic test_timeout();
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (k == 999) begin
                n_tests++; if (ddr_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0 at cycle 999", ddr_timeout); end
            end
        end
        n_tests++; if (ddr_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1 at cycle 1000", ddr_timeout); end
        n_tests++; if (ddr_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_ready: got %b want 0", ddr_ready); end
        ddr_init_done = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_tests++; if (ddr_ready !== (k == 17)) begin n_fail++; $display("FAIL fault_settle_ready: got %b want %b at cycle %0d", ddr_ready, (k == 17), k); end
        end
        n_tests++; if (ddr_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", ddr_timeout); end
    endtask

    task automatic test_settle_timing();
        do_reset();
        n_tests++; if (ddr_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: got %b want 0", ddr_timeout); end
        s_awvalid = 1'b1; m_awready = 1'b1;
        repeat (5) tick();
        ddr_init_done = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            #1;
            n_tests++; if (ddr_ready !== (k == 17)) begin n_fail++; $display("FAIL settle_ready: got %b want %b at cycle %0d", ddr_ready, (k == 17), k); end
            if (k < 17) begin
                n_tests++; if ({s_awready, m_awvalid} !== 2'b00) begin
                    n_fail++; $display("FAIL settle_gate_closed: got %b want 00 at cycle %0d", {s_awready, m_awvalid}, k);
                end
            end
        end
        s_awvalid = 1'b0; m_awready = 1'b0;
    endtask

    task automatic test_settle_abort();
        do_reset();
        ddr_init_done = 1'b1;
        repeat (5) tick();
        ddr_init_done = 1'b0;
        tick();
        n_tests++; if (ddr_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ddr_ready); end
        repeat (3) tick();
        ddr_init_done = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_tests++; if (ddr_ready !== (k == 17)) begin n_fail++; $display("FAIL abort_resettle: got %b want %b at cycle %0d", ddr_ready, (k == 17), k); end
        end
    endtask

    task automatic test_wr_limit();
        m_awready = 1'b1; s_awvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++; if ({s_awready, m_awvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_fill_accept: got %b want 11 at aw %0d", {s_awready, m_awvalid}, i); end
            tick();
        end
        #1;
        n_tests++; if (wr_outstanding !== 4'd8) begin n_fail++; $display("FAIL wr_full_count: got %0d want 8", wr_outstanding); end
        n_tests++; if ({s_awready, m_awvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_full_block: got %b want 00", {s_awready, m_awvalid}); end
        s_awvalid = 1'b0; bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        n_tests++; if (wr_outstanding !== 4'd7) begin n_fail++; $display("FAIL wr_after_b: got %0d want 7", wr_outstanding); end
        s_awvalid = 1'b1;
        #1;
        n_tests++; if ({s_awready, m_awvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_reopen: got %b want 11", {s_awready, m_awvalid}); end
        tick();
        s_awvalid = 1'b0;
        #1;
        n_tests++; if (wr_outstanding !== 4'd8) begin n_fail++; $display("FAIL wr_refill: got %0d want 8", wr_outstanding); end
        bvalid = 1'b1;
        repeat (9) tick();
        bvalid = 1'b0; bready = 1'b0; m_awready = 1'b0;
        #1;
        n_tests++; if (wr_outstanding !== 4'd0) begin n_fail++; $display("FAIL wr_drain_floor: got %0d want 0", wr_outstanding); end
    endtask

    task automatic test_rd_simul();
        s_arvalid = 1'b1; m_arready = 1'b1;
        repeat (3) tick();
        s_arvalid = 1'b0;
        #1;
        n_tests++; if (rd_outstanding !== 4'd3) begin n_fail++; $display("FAIL rd_fill: got %0d want 3", rd_outstanding); end
        s_arvalid = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        tick();
        s_arvalid = 1'b0;
        #1;
        n_tests++; if (rd_outstanding !== 4'd3) begin n_fail++; $display("FAIL rd_simultaneous: got %0d want 3", rd_outstanding); end
        rlast = 1'b0;
        tick();
        #1;
        n_tests++; if (rd_outstanding !== 4'd3) begin n_fail++; $display("FAIL rd_nonlast_beat: got %0d want 3", rd_outstanding); end
        rlast = 1'b1;
        repeat (3) tick();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; m_arready = 1'b0;
        #1;
        n_tests++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL rd_drain: got %0d want 0", rd_outstanding); end
    endtask

    // Model: each direction is a count of issued-but-uncompleted transactions,
    // admission allowed only while fewer than 8 are in flight.
    task automatic test_random();
        bit aw_hs, ar_hs, b_done, r_fin, ok_aw, ok_ar;
        m_wr = 0; m_rd = 0;
        for (int i = 0; i < 400; i++) begin
            s_awvalid = 1'($urandom_range(0, 1)); m_awready = 1'($urandom_range(0, 1));
            s_arvalid = 1'($urandom_range(0, 1)); m_arready = 1'($urandom_range(0, 1));
            bvalid = 1'($urandom_range(0, 1));    bready = 1'($urandom_range(0, 1));
            rvalid = 1'($urandom_range(0, 1));    rready = 1'($urandom_range(0, 1));
            rlast = 1'($urandom_range(0, 1));
            #1;
            ok_aw = (m_wr < 8);
            ok_ar = (m_rd < 8);
            n_tests++; if ({m_awvalid, s_awready} !== {s_awvalid && ok_aw, m_awready && ok_aw}) begin
                n_fail++; $display("FAIL rand_aw_gate: got %b want %b at iter %0d", {m_awvalid, s_awready}, {s_awvalid && ok_aw, m_awready && ok_aw}, i);
            end
            n_tests++; if ({m_arvalid, s_arready} !== {s_arvalid && ok_ar, m_arready && ok_ar}) begin
                n_fail++; $display("FAIL rand_ar_gate: got %b want %b at iter %0d", {m_arvalid, s_arready}, {s_arvalid && ok_ar, m_arready && ok_ar}, i);
            end
            aw_hs  = s_awvalid && m_awready && ok_aw;
            ar_hs  = s_arvalid && m_arready && ok_ar;
            b_done = bvalid && bready;
            r_fin  = rvalid && rready && rlast;
            if (aw_hs && !b_done) m_wr++;
            else if (b_done && !aw_hs && m_wr > 0) m_wr--;
            if (ar_hs && !r_fin) m_rd++;
            else if (r_fin && !ar_hs && m_rd > 0) m_rd--;
            tick();
            #1;
            n_tests++; if (wr_outstanding !== 4'(m_wr)) begin n_fail++; $display("FAIL rand_wr_count: got %0d want %0d at iter %0d", wr_outstanding, m_wr, i); end
            n_tests++; if (rd_outstanding !== 4'(m_rd)) begin n_fail++; $display("FAIL rand_rd_count: got %0d want %0d at iter %0d", rd_outstanding, m_rd, i); end
        end
        clear_inputs();
        ddr_init_done = 1'b1;
    endtask

    task automatic test_ready_drop();
        do_reset();
        ddr_init_done = 1'b1;
        repeat (17) tick();
        s_awvalid = 1'b1; m_awready = 1'b1;
        repeat (5) tick();
        s_awvalid = 1'b0; s_arvalid = 1'b1; m_arready = 1'b1;
        repeat (2) tick();
        s_arvalid = 1'b0;
        #1;
        n_tests++; if ({wr_outstanding, rd_outstanding} !== {4'd5, 4'd2}) begin
            n_fail++; $display("FAIL drop_setup: got wr=%0d rd=%0d want wr=5 rd=2", wr_outstanding, rd_outstanding);
        end
        ddr_init_done = 1'b0;
        tick();
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        n_tests++; if (ddr_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", ddr_ready); end
        n_tests++; if ({m_awvalid, s_awready, m_arvalid, s_arready} !== 4'b0000) begin
            n_fail++; $display("FAIL drop_gate: got %b want 0000", {m_awvalid, s_awready, m_arvalid, s_arready});
        end
        tick();
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        ddr_init_done = 1'b1;
        repeat (17) tick();
        #1;
        n_tests++; if (ddr_ready !== 1'b1) begin n_fail++; $display("FAIL drop_reopen: got %b want 1", ddr_ready); end
        n_tests++; if ({wr_outstanding, rd_outstanding} !== {4'd5, 4'd2}) begin
            n_fail++; $display("FAIL drop_retained: got wr=%0d rd=%0d want wr=5 rd=2", wr_outstanding, rd_outstanding);
        end
    endtask

    task automatic test_reset_mid();
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #2;
        ddr_rstn_i = 1'b0;
        #1;
        n_tests++; if ({ddr_ready, ddr_timeout} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags: got %b want 00", {ddr_ready, ddr_timeout}); end
        n_tests++; if ({wr_outstanding, rd_outstanding} !== 8'd0) begin
            n_fail++; $display("FAIL midreset_counts: got wr=%0d rd=%0d want 0 0", wr_outstanding, rd_outstanding);
        end
        n_tests++; if ({m_awvalid, s_awready, m_arvalid, s_arready} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_gate: got %b want 0000", {m_awvalid, s_awready, m_arvalid, s_arready});
        end
        clear_inputs();
        @(negedge clk);
        ddr_rstn_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_settle_timing();
        test_settle_abort();
        test_wr_limit();
        test_rd_simul();
        test_random();
        test_ready_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
